// File: rtl/sd_spi_cmd.sv
// SD-card SPI command engine: sends one 48-bit command frame, collects the R1 byte, then clocks 8 idle bits with CS high.
// Latency (48+8+8+8*wait_bytes)*2*CLK_DIV clk cycles start->done; start is ignored while busy.
module sd_spi_cmd #(
    parameter int CLK_DIV      = 125,
    parameter int RESP_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] arg,
    output logic        busy,
    output logic        done,
    output logic [7:0]  resp,
    output logic        timeout,
    output logic        SCLK,
    output logic        CS,
    output logic        D1,
    input  logic        D0
);

    localparam int DIV_W     = $clog2(CLK_DIV);
    localparam int WAIT_BITS = RESP_TIMEOUT * 8;
    localparam int WAIT_W    = $clog2(WAIT_BITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_RESP,
        RESP,
        POST
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [DIV_W-1:0]    div_cnt;
    logic                sclk_q;
    logic                cs_q;
    logic                done_q;
    logic                timeout_q;
    logic [7:0]          resp_q;
    logic [47:0]         tx_q;
    logic [5:0]          bit_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                tick;
    logic                rise;
    logic                fall;
    logic [39:0]         frame_head;
    logic [47:0]         frame_new;

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    assign busy       = (state != IDLE);
    assign tick       = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign rise       = busy && tick && !sclk_q;
    assign fall       = busy && tick && sclk_q;
    assign frame_head = {2'b01, cmd_index, arg};
    assign frame_new  = {frame_head, crc7(frame_head), 1'b1};

    assign SCLK    = sclk_q;
    assign CS      = cs_q;
    assign D1      = tx_q[47];
    assign done    = done_q;
    assign resp    = resp_q;
    assign timeout = timeout_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start) state_nxt = SEND;
            SEND:      if (rise && bit_cnt == 6'd47) state_nxt = WAIT_RESP;
            WAIT_RESP: if (rise) begin
                           if (!D0)                                  state_nxt = RESP;
                           else if (wait_cnt == WAIT_W'(WAIT_BITS - 1)) state_nxt = POST;
                       end
            RESP:      if (rise && bit_cnt == 6'd6) state_nxt = POST;
            POST:      if (fall && bit_cnt == 6'd8) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt   <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            resp_q    <= 8'hFF;
            tx_q      <= '1;
            bit_cnt   <= '0;
            wait_cnt  <= '0;
        end else begin
            done_q <= 1'b0;
            if (busy) begin
                if (tick) begin
                    div_cnt <= '0;
                    sclk_q  <= ~sclk_q;
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end else begin
                div_cnt <= '0;
                sclk_q  <= 1'b0;
            end
            // Ones shift in behind the frame, so MOSI idles high once the stop bit is out
            if (fall) tx_q <= {tx_q[46:0], 1'b1};
            case (state)
                IDLE: if (start) begin
                    tx_q      <= frame_new;
                    cs_q      <= 1'b0;
                    timeout_q <= 1'b0;
                    bit_cnt   <= '0;
                    wait_cnt  <= '0;
                end
                SEND: if (rise) bit_cnt <= (bit_cnt == 6'd47) ? 6'd0 : bit_cnt + 6'd1;
                WAIT_RESP: if (rise) begin
                    if (!D0) begin
                        resp_q  <= {resp_q[6:0], D0};
                        bit_cnt <= '0;
                    end else if (wait_cnt == WAIT_W'(WAIT_BITS - 1)) begin
                        resp_q    <= 8'hFF;
                        timeout_q <= 1'b1;
                        cs_q      <= 1'b1;
                        bit_cnt   <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                RESP: if (rise) begin
                    resp_q <= {resp_q[6:0], D0};
                    if (bit_cnt == 6'd6) begin
                        cs_q    <= 1'b1;
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                POST: begin
                    if (rise) bit_cnt <= bit_cnt + 6'd1;
                    if (fall && bit_cnt == 6'd8) done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
